// File: rtl/hold_gate_meter.sv
// hold_gate_meter
//
// Purpose: monitors the gate (g) and toggle (f) produced by the upstream
// hold-style gate FSM. For every completed gate window it records the window
// length in clock cycles, whether f changed inside the window, and whether
// the length is outside [MIN_LEN, MAX_LEN]. Results are offered one at a
// time on a valid/ready result port.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   g, f       gate and toggle from the upstream FSM (already registered)
//   res_ready  consumer accepts the current result
//   res_valid  result register holds an unread result
//   res_len    window length, saturated at MAX_LEN+1
//   res_tog    f changed at least once during the window
//   res_short  length < MIN_LEN
//   res_long   length > MAX_LEN
//   ovf        sticky: a completed result was dropped (cleared by rst only)
//   win_cnt    completed windows including dropped ones, wraps 255->0
//   busy       high while a window is being measured
//   dbg_state  current FSM state (0 ARM, 1 IDLE, 2 MEAS)
//
// Result handshake: a result transfers on any rising edge where
// res_valid & res_ready are both high. While res_valid is high and
// res_ready is low, every res_* field holds steady. A new window result may
// be loaded on the same edge that the previous one transfers; otherwise a
// result completed while the register is still full is dropped and ovf set.
// res_ready has no effect while res_valid is low.

module hold_gate_meter #(
    parameter int MIN_LEN = 4,
    parameter int MAX_LEN = 15,
    parameter int LEN_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             g,
    input  logic             f,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [LEN_W-1:0] res_len,
    output logic             res_tog,
    output logic             res_short,
    output logic             res_long,
    output logic             ovf,
    output logic [7:0]       win_cnt,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_IDLE = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

    state_t           state;
    logic             f_q;
    logic [LEN_W-1:0] len;
    logic             tog;

    logic tog_ev;
    logic commit;
    logic drain;

    assign tog_ev = f ^ f_q;
    // The first low sample of g closes the window; that cycle contributes
    // neither length nor toggle.
    assign commit = (state == ST_MEAS) && !g;
    assign drain  = res_valid && res_ready;

    assign busy      = (state == ST_MEAS);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ARM;
            f_q       <= 1'b0;
            len       <= '0;
            tog       <= 1'b0;
            res_valid <= 1'b0;
            res_len   <= '0;
            res_tog   <= 1'b0;
            res_short <= 1'b0;
            res_long  <= 1'b0;
            ovf       <= 1'b0;
            win_cnt   <= 8'd0;
        end else begin
            f_q <= f;

            case (state)
                // Wait for the gate to be low so a window already open at
                // reset is never measured partially.
                ST_ARM: begin
                    if (!g) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (g) begin
                        state <= ST_MEAS;
                        len   <= LEN_ONE;
                        tog   <= tog_ev;
                    end
                end
                ST_MEAS: begin
                    if (g) begin
                        if (len != LEN_SAT) len <= len + LEN_ONE;
                        tog <= tog | tog_ev;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_ARM;
            endcase

            if (commit) begin
                if (!res_valid || res_ready) begin
                    res_valid <= 1'b1;
                    res_len   <= len;
                    res_tog   <= tog;
                    res_short <= (len < LEN_MIN);
                    res_long  <= (len > LEN_MAX);
                end else begin
                    ovf <= 1'b1;
                end
                win_cnt <= win_cnt + 8'd1;
            end else if (drain) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hold_gate_meter.sv
// Directed bench for hold_gate_meter. Inputs change 1 time unit after each
// rising edge; outputs are checked at that same point, well away from the
// next active edge.

module tb_hold_gate_meter;

    localparam int LEN_W = 5;

    logic             clk;
    logic             rst;
    logic             g;
    logic             f;
    logic             res_ready;
    logic             res_valid;
    logic [LEN_W-1:0] res_len;
    logic             res_tog;
    logic             res_short;
    logic             res_long;
    logic             ovf;
    logic [7:0]       win_cnt;
    logic             busy;
    logic [1:0]       dbg_state;

    int total;
    int bad;

    logic [LEN_W-1:0] exp_q[$];

    hold_gate_meter #(
        .MIN_LEN(4),
        .MAX_LEN(15),
        .LEN_W  (LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .g        (g),
        .f        (f),
        .res_ready(res_ready),
        .res_valid(res_valid),
        .res_len  (res_len),
        .res_tog  (res_tog),
        .res_short(res_short),
        .res_long (res_long),
        .ovf      (ovf),
        .win_cnt  (win_cnt),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // reset, then one low-gate cycle so the meter leaves ARM
    task automatic do_reset();
        rst = 1'b1;
        g   = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // n cycles with g high; f flips at the start of high cycle tog_at (0 = never)
    task automatic high_cycles(input int n, input int tog_at);
        for (int i = 1; i <= n; i++) begin
            g = 1'b1;
            if (i == tog_at) f = ~f;
            tick();
        end
    endtask

    task automatic close_window();
        g = 1'b0;
        tick();
    endtask

    int lens[5]      = '{3, 4, 15, 16, 20};
    int exp_lens[5]  = '{3, 4, 15, 16, 16};
    int exp_short[5] = '{1, 0, 0, 0, 0};
    int exp_long[5]  = '{0, 0, 0, 1, 1};

    initial begin
        logic [LEN_W-1:0] e;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        g         = 1'b0;
        f         = 1'b0;
        res_ready = 1'b0;
        tick();

        // reset values
        check("rst_valid", 32'(res_valid), 0);
        check("rst_len",   32'(res_len), 0);
        check("rst_flags", {29'd0, res_tog, res_short, res_long}, 0);
        check("rst_ovf",   32'(ovf), 0);
        check("rst_cnt",   32'(win_cnt), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_state", 32'(dbg_state), 0);

        // nominal 7-cycle window, f toggles on the 6th high cycle
        rst       = 1'b0;
        res_ready = 1'b1;
        tick();
        high_cycles(7, 6);
        check("nom_busy", 32'(busy), 1);
        close_window();
        check("nom_valid", 32'(res_valid), 1);
        check("nom_len",   32'(res_len), 7);
        check("nom_tog",   32'(res_tog), 1);
        check("nom_short", 32'(res_short), 0);
        check("nom_long",  32'(res_long), 0);
        check("nom_cnt",   32'(win_cnt), 1);
        check("nom_idle",  32'(busy), 0);
        tick();
        check("nom_pulse", 32'(res_valid), 0);

        // length limits
        for (int k = 0; k < 5; k++) exp_q.push_back(LEN_W'(exp_lens[k]));
        for (int k = 0; k < 5; k++) begin
            high_cycles(lens[k], 0);
            close_window();
            e = exp_q.pop_front();
            check("lim_valid", 32'(res_valid), 1);
            check("lim_len",   32'(res_len), 32'(e));
            check("lim_short", 32'(res_short), 32'(exp_short[k]));
            check("lim_long",  32'(res_long), 32'(exp_long[k]));
            check("lim_tog",   32'(res_tog), 0);
            check("lim_cnt",   32'(win_cnt), 32'(k + 2));
            tick();
        end

        // backpressure: three 5-cycle windows with res_ready low
        res_ready = 1'b0;
        do_reset();
        high_cycles(5, 2);
        close_window();
        check("bp1_len", 32'(res_len), 5);
        check("bp1_tog", 32'(res_tog), 1);
        check("bp1_ovf", 32'(ovf), 0);
        high_cycles(5, 0);
        close_window();
        check("bp2_ovf",   32'(ovf), 1);
        check("bp2_hold",  32'(res_tog), 1);
        high_cycles(5, 0);
        close_window();
        check("bp3_valid", 32'(res_valid), 1);
        check("bp3_len",   32'(res_len), 5);
        check("bp3_tog",   32'(res_tog), 1);
        check("bp3_cnt",   32'(win_cnt), 3);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("bp_drain", 32'(res_valid), 0);
        check("bp_ovf_sticky", 32'(ovf), 1);

        // simultaneous accept and commit
        do_reset();
        high_cycles(4, 0);
        close_window();
        check("sim_first", 32'(res_len), 4);
        high_cycles(6, 0);
        res_ready = 1'b1;
        close_window();
        check("sim_valid", 32'(res_valid), 1);
        check("sim_len",   32'(res_len), 6);
        check("sim_ovf",   32'(ovf), 0);
        check("sim_cnt",   32'(win_cnt), 2);
        tick();
        check("sim_drain", 32'(res_valid), 0);

        // reset mid-window with g still high
        do_reset();
        high_cycles(3, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmw_busy", 32'(busy), 0);
        tick();
        tick();
        check("rmw_arm",  32'(dbg_state), 0);
        close_window();
        check("rmw_novalid", 32'(res_valid), 0);
        check("rmw_cnt",     32'(win_cnt), 0);
        high_cycles(5, 0);
        close_window();
        check("rmw_len",  32'(res_len), 5);
        check("rmw_cnt2", 32'(win_cnt), 1);

        // reset while a result is pending
        res_ready = 1'b0;
        high_cycles(3, 0);
        close_window();
        check("rpv_valid", 32'(res_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rpv_clear", 32'(res_valid), 0);
        check("rpv_cnt",   32'(win_cnt), 0);
        check("rpv_len",   32'(res_len), 0);

        // f toggles only on the first low cycle after the window
        res_ready = 1'b1;
        do_reset();
        high_cycles(4, 0);
        g = 1'b0;
        f = ~f;
        tick();
        check("edge_valid", 32'(res_valid), 1);
        check("edge_tog",   32'(res_tog), 0);
        tick();

        // 256 one-cycle windows wrap win_cnt
        do_reset();
        high_cycles(1, 0);
        close_window();
        check("one_len",   32'(res_len), 1);
        check("one_short", 32'(res_short), 1);
        for (int k = 1; k < 255; k++) begin
            high_cycles(1, 0);
            close_window();
        end
        check("wrap_255", 32'(win_cnt), 255);
        high_cycles(1, 0);
        close_window();
        check("wrap_0",   32'(win_cnt), 0);
        check("wrap_ovf", 32'(ovf), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hold_gate_meter.md
# hold_gate_meter

Downstream checker for the hold-style gate FSM: samples the gate `g` and toggle `f` that FSM produces, measures each gate window's length in clock cycles, records whether `f` toggled inside the window, and flags windows outside a legal length range. Each completed window yields one result word on a valid/ready interface, read by the status/register stage. Used as a bring-up monitor and in-system sanity check of the gate generator.

## Interface
- `MIN_LEN`, 4, shortest legal window (cycles); must be ≥ 1
- `MAX_LEN`, 15, longest legal window (cycles); must be ≥ `MIN_LEN`
- `LEN_W`, 5, length field width; must satisfy 2^`LEN_W` > `MAX_LEN`+1

- `clk` input 1 system clock; all logic on rising edge
- `rst` input 1 synchronous, active-high reset
- `g` input 1 gate from upstream FSM (registered there)
- `f` input 1 toggle from upstream FSM (registered there)
- `res_ready` input 1 consumer accepts result
- `res_valid` output 1 result register holds an unread result
- `res_len` output `LEN_W` window length, saturated at `MAX_LEN`+1
- `res_tog` output 1 `f` changed at least once during the window
- `res_short` output 1 length < `MIN_LEN`
- `res_long` output 1 length > `MAX_LEN`
- `ovf` output 1 sticky: a completed result was dropped
- `win_cnt` output 8 completed windows, dropped ones included
- `busy` output 1 high while in MEAS

## Operation
- Input flops: `f_q` holds previous-cycle `f`; toggle event = `f` != `f_q`.
- States:
  - ARM: reset state; waits for `g`==0, then → IDLE. Stops a window already open at reset from being measured partially.
  - IDLE: `g`==1 → MEAS, `len`←1, `tog`←toggle event.
  - MEAS: `g`==1 → stay; `len`←`len`+1, saturating at `MAX_LEN`+1; `tog`←`tog` | toggle event. `g`==0 → commit, → IDLE.
- Commit: candidate = {`len`, `tog`, `len`<`MIN_LEN`, `len`>`MAX_LEN`}. The cycle where `g` is first sampled low counts neither toward length nor toward `tog`.
  - Result register empty, or drained this same cycle (`res_valid` & `res_ready`): load candidate; `res_valid`←1.
  - Otherwise: drop candidate; `ovf`←1.
  - `win_cnt`←`win_cnt`+1 in both cases, wrapping 255→0.
- Handshake: `res_valid` & `res_ready` with no commit that cycle → `res_valid`←0. Result fields hold steady while `res_valid`=1 and the result is not accepted. `res_ready` while `res_valid`=0 has no effect.
- `ovf` clears only on `rst`.
- `busy` = (state == MEAS).

## Timing
- Reset values: state ARM; `res_valid` 0; `res_len` 0; `res_tog`, `res_short`, `res_long` 0; `ovf` 0; `win_cnt` 0; `busy` 0; `f_q` 0.
- `rst` overrides every event in the same cycle, including an open window and a pending result; both are discarded.
- Window of N high cycles: `busy` rises the cycle after `g` is first sampled high. `res_valid` rises the cycle after `g` is first sampled low.
- Back-to-back windows: `g` low for one cycle, then high again. The commit and IDLE→MEAS occur on consecutive edges, so no window is missed.
- Minimum window length is 1 cycle; it reports `res_short`=1 whenever `MIN_LEN` > 1.
- Saturation: a window longer than `MAX_LEN`+1 cycles reports `res_len`=`MAX_LEN`+1 and `res_long`=1.
- Throughput: one result per window; with `res_ready` tied high, no result is ever dropped.
- Combinational input→output paths: none. All outputs are registered.

## Test plan
- Nominal: `g` high 7 cycles, `f` toggles once on the 6th high cycle, `res_ready`=1 → `res_valid` pulses 1 cycle; `res_len`=7, `res_tog`=1, `res_short`=0, `res_long`=0; `win_cnt`=1.
- Length limits with defaults: windows of 3, 4, 15, 16 and 20 cycles →
  - 3: `res_len`=3, `res_short`=1
  - 4 and 15: both error flags 0
  - 16: `res_len`=16, `res_long`=1
  - 20: `res_len`=16 (saturated), `res_long`=1
- Backpressure: `res_ready`=0, three 5-cycle windows → first result held unchanged, `ovf`=1 after the second commit, `win_cnt`=3. Raising `res_ready` for 1 cycle then drops `res_valid`.
- Simultaneous accept and commit: `res_valid`=1 and `res_ready`=1 on the commit edge of a 6-cycle window → new result loaded, `res_valid` stays 1, `ovf` stays 0.
- Reset handling:
  - `rst` for 1 cycle mid-window with `g` still high → ARM; no result for that window. The next full 5-cycle window reports `res_len`=5.
  - `rst` while `res_valid`=1 → `res_valid`=0, `win_cnt`=0.
- Toggle edge and wrap: `f` toggles only on the first low cycle after a window → `res_tog`=0. 256 one-cycle windows → `win_cnt` wraps to 0.
